encoder_pixel_loader: RTL and testbench
=======================================

Name: encoder_pixel_loader

Overview:
- Sits directly upstream of the Encoder and drives its Pixel_data / EnableReadPixel inputs.
- Accepts one 28x28 frame of 8-bit grayscale pixels over a valid/ready byte stream and buffers the whole frame.
- Converts each pixel to Q10.10.
- Issues a one-cycle EnableReadPixel pulse, then presents the 784 pixels on consecutive cycles, matching the Encoder's write-capture timing.

Parameters:
- PIXELS, 784, pixels per frame (28*28).
- IN_W, 8, input pixel width.
- INTEGER_W, 10, integer bits of output fixed-point.
- FRACTION_W, 10, fraction bits of output fixed-point.
- ADDR_W, 10, frame buffer address width; must satisfy 2^ADDR_W >= PIXELS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  loader can accept a byte.
- in_data  in  IN_W  pixel byte, row-major order, pixel 0 first.
- Pixel_data  out  INTEGER_W+FRACTION_W  converted pixel to the Encoder.
- EnableReadPixel  out  1  one-cycle start pulse to the Encoder.
- next_frame  in  1  re-arms the loader after the Encoder has been reset for the next frame.
- busy  out  1  high in any state other than FILL.
- frame_done  out  1  one-cycle pulse after the last pixel is presented.

Behaviour:
- Reset (reset=0, asynchronous) forces: state=FILL, write and read counters=0, in_ready=0, EnableReadPixel=0, Pixel_data=0, busy=0, frame_done=0. in_ready rises on the first clock edge after reset release.
- Reset asserted mid-frame discards the partial frame; nothing is emitted.
- FILL:
  - in_ready=1.
  - On each edge with in_valid&in_ready, store the converted pixel at wr_cnt and increment wr_cnt.
  - When the byte at wr_cnt=PIXELS-1 is accepted: go to PULSE, in_ready=0 from the next cycle, wr_cnt=0.
- PULSE:
  - EnableReadPixel=1 for exactly one cycle (cycle T).
  - Preload buffer address 0.
  - Go to STREAM.
- STREAM:
  - Pixel k is on Pixel_data throughout cycle T+1+k, k=0..PIXELS-1, with no gaps.
  - Buffer read latency is hidden by preloading in PULSE.
  - After pixel PIXELS-1 is presented: Pixel_data returns to 0, frame_done pulses in cycle T+1+PIXELS, go to HOLD.
- HOLD:
  - in_ready=0; Pixel_data=0.
  - next_frame=1 causes FILL on the next cycle.
  - next_frame is ignored in every other state.
- The Encoder captures only one frame per reset, so a new frame is never emitted without next_frame.
- in_valid is ignored while in_ready=0.
- A byte accepted on the same edge as the PIXELS-1 transition is the last pixel; no byte is accepted in PULSE.
- Conversion (normalised mode):
  - q = (p*1028 + 128) >> 8, a 19-bit intermediate.
  - Results: p=0 gives 0, p=1 gives 4, p=128 gives 514, p=255 gives 1024 (1.0).
  - Result is zero-extended to INTEGER_W+FRACTION_W and is always non-negative.
- Total frame latency: last byte accepted at edge E; EnableReadPixel high in the cycle after E; pixel 0 in the cycle after that.

Optional Feature:
- Macro: PIXEL_NORMALIZE_EN.
- Defined: pixel scaled to [0,1.0] in Q10.10 as above.
- Undefined: no multiplier; output = {p, FRACTION_W zeros}, i.e. the raw integer value. p=255 gives 0x3FC00.
- Timing is identical in both modes.

Decomposition:
- Shared package encoder_pkg:
  - Constants INPUT_PIXEL_SIZE=28, INPUT_TOTAL=784, INTEGER_WIDTH=10, FRACTION_WIDTH=10.
  - Fixed-point word typedef fx_t (20 bits).
  - Loader state enum (FILL, PULSE, STREAM, HOLD).
- One natural sub-module: pixel_normalizer. It is combinational, byte in, fx_t out, and holds the PIXEL_NORMALIZE_EN branch. It sits on the write path so the buffer stores converted words.
- Frame buffer: an inferred single-port RAM, PIXELS x 20.

Test Plan:
- Reset, then 784 bytes p=k mod 256 with in_valid held high -> in_ready drops after byte 783; one EnableReadPixel pulse; Pixel_data in cycle T+1+k equals norm(k mod 256), e.g. k=255 gives 1024, k=1 gives 4; frame_done pulses at T+785.
- Bursty input with in_valid toggling randomly, frame all 0xFF -> all 784 outputs equal 1024 with no gaps; exactly one EnableReadPixel.
- In HOLD, drive in_valid=1 for 100 cycles, then pulse next_frame and send a frame of 0x80 -> no bytes accepted in HOLD; second frame streams 514 for all pixels.
- Assert reset after 400 bytes, then send a full frame of 0x10 -> no EnableReadPixel from the partial frame; the new frame streams norm(16)=64.
- Build without PIXEL_NORMALIZE_EN, pixels 0, 1, 255 -> outputs 0x00000, 0x00400, 0x3FC00; timing identical to the normalised build.
- Connect to the Encoder and load a known MNIST frame -> Encoder BRAM8 contents match the loader buffer for all 784 addresses.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared encoder constants, the Q10.10 word type and the pixel loader state encoding.
package encoder_pkg;
   localparam int unsigned INPUT_PIXEL_SIZE = 28;
   localparam int unsigned INPUT_TOTAL      = INPUT_PIXEL_SIZE * INPUT_PIXEL_SIZE;
   localparam int unsigned INTEGER_WIDTH    = 10;
   localparam int unsigned FRACTION_WIDTH   = 10;

   typedef logic [INTEGER_WIDTH+FRACTION_WIDTH-1:0] fx_t;

   typedef enum logic [1:0] {FILL, PULSE, STREAM, HOLD} loader_state_t;
endpackage

// File: rtl/encoder_pixel_loader_if.sv
// Upstream valid/ready byte stream feeding the encoder pixel loader.
interface encoder_pixel_loader_if #(parameter int unsigned IN_W = 8);
   logic            in_valid;
   logic            in_ready;
   logic [IN_W-1:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pixel_normalizer.sv
// Byte-to-Q10.10 conversion on the buffer write path.
// PIXEL_NORMALIZE_EN: defined scales to [0,1.0]; undefined passes the raw integer value.
module pixel_normalizer
   import encoder_pkg::*;
#(
   parameter int unsigned IN_W = 8
) (
   input  logic [IN_W-1:0] pixel,
   output fx_t             word
);
`ifdef PIXEL_NORMALIZE_EN
   // 1028/256 maps 255 onto 1024 (1.0); +128 rounds the dropped byte
   logic [18:0] prod;
   logic [18:0] scaled;

   always_comb begin
      prod   = 19'(pixel) * 19'd1028 + 19'd128;
      scaled = prod >> 8;
      word   = fx_t'(scaled);
   end
`else
   always_comb begin
      word = fx_t'({pixel, {FRACTION_WIDTH{1'b0}}});
   end
`endif
endmodule

// File: rtl/encoder_pixel_loader.sv
// Buffers one 28x28 frame of converted pixels, then pulses EnableReadPixel and streams it gap-free.
// Conversion mode is selected by PIXEL_NORMALIZE_EN (see pixel_normalizer).
module encoder_pixel_loader
   import encoder_pkg::*;
#(
   parameter int unsigned PIXELS     = INPUT_TOTAL,
   parameter int unsigned IN_W       = 8,
   parameter int unsigned INTEGER_W  = INTEGER_WIDTH,
   parameter int unsigned FRACTION_W = FRACTION_WIDTH,
   parameter int unsigned ADDR_W     = 10
) (
   input  logic                            clk,
   input  logic                            reset,
   encoder_pixel_loader_if.slave           in_if,
   output logic [INTEGER_W+FRACTION_W-1:0] Pixel_data,
   output logic                            EnableReadPixel,
   input  logic                            next_frame,
   output logic                            busy,
   output logic                            frame_done
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

   loader_state_t   state, state_next;
   logic [ADDR_W-1:0] wr_cnt, rd_cnt, ram_addr;
   logic            in_ready_q, accept, last_in, last_out;
   fx_t             wr_word, rd_word;
   fx_t             mem [PIXELS];

   pixel_normalizer #(.IN_W(IN_W)) u_norm (
      .pixel (in_if.in_data),
      .word  (wr_word)
   );

   assign in_if.in_ready = in_ready_q;
   assign accept   = in_if.in_valid & in_ready_q;
   assign last_in  = accept && (wr_cnt == LAST);
   assign last_out = (state == STREAM) && (rd_cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FILL;
      else        state <= state_next;
   end

   always_comb begin
      state_next      = state;
      EnableReadPixel = 1'b0;
      busy            = 1'b1;
      Pixel_data      = '0;
      ram_addr        = '0;
      unique case (state)
         FILL: begin
            busy     = 1'b0;
            ram_addr = wr_cnt;
            if (last_in) state_next = PULSE;
         end
         PULSE: begin
            EnableReadPixel = 1'b1;
            state_next      = STREAM;
         end
         STREAM: begin
            // read one ahead so the RAM latency stays hidden behind the pixel on the bus
            Pixel_data = (INTEGER_W+FRACTION_W)'(rd_word);
            ram_addr   = rd_cnt + ADDR_W'(1);
            if (last_out) state_next = HOLD;
         end
         HOLD: begin
            if (next_frame) state_next = FILL;
         end
         default: state_next = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         in_ready_q <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (accept) wr_cnt <= last_in ? '0 : wr_cnt + ADDR_W'(1);
         if (state == STREAM) rd_cnt <= last_out ? '0 : rd_cnt + ADDR_W'(1);
         else                 rd_cnt <= '0;
         in_ready_q <= (state_next == FILL);
         frame_done <= last_out;
      end
   end

   always_ff @(posedge clk) begin
      if (accept)                          mem[ram_addr] <= wr_word;
      else if (ram_addr < ADDR_W'(PIXELS)) rd_word       <= mem[ram_addr];
   end
endmodule

// File: tb/tb_encoder_pixel_loader.sv
// Directed-sequence bench with randomized bytes/valid, checked against an arithmetic frame model.
module tb_encoder_pixel_loader;
   localparam int unsigned NPIX = 784;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        next_frame = 1'b0;
   logic [19:0] Pixel_data;
   logic        EnableReadPixel, busy, frame_done;

   int unsigned vectors = 0;
   int unsigned misses  = 0;
   logic [7:0]  exp_q [$];
   logic [19:0] got [NPIX];

   encoder_pixel_loader_if #(.IN_W(8)) bus ();

   encoder_pixel_loader dut (
      .clk             (clk),
      .reset           (rst_n),
      .in_if           (bus.slave),
      .Pixel_data      (Pixel_data),
      .EnableReadPixel (EnableReadPixel),
      .next_frame      (next_frame),
      .busy            (busy),
      .frame_done      (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] conv(input logic [7:0] p);
`ifdef PIXEL_NORMALIZE_EN
      return (32'(p) * 1028 + 128) / 256;
`else
      return 32'(p) * 1024;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         misses++;
         $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
      end
   endtask

   // kind 0: ramp k mod 256, kind 1: constant val, kind 2: random bytes
   task automatic send(input int unsigned n, input int unsigned kind, input logic [7:0] val,
                       input bit bursty);
      int unsigned sent = 0, cyc = 0, en_seen = 0;
      logic [7:0] d;
      exp_q.delete();
      while (sent < n && cyc < 20000) begin
         @(negedge clk);
         if (EnableReadPixel) en_seen++;
         d = (kind == 0) ? 8'(sent) : (kind == 1) ? val : 8'($urandom);
         bus.in_data  = d;
         bus.in_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(d);
            sent++;
         end
         cyc++;
      end
      check("fill_count", sent, n);
      check("fill_no_pulse", en_seen, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic stream_check(input string name);
      int unsigned pulses, dones;
      check({name, "_ready_drop"}, 32'(bus.in_ready), 0);
      check({name, "_pulse_T"}, 32'(EnableReadPixel), 1);
      check({name, "_busy_T"}, 32'(busy), 1);
      pulses = 0;
      dones  = 0;
      for (int k = 0; k < NPIX; k++) begin
         @(negedge clk);
         got[k] = Pixel_data;
         if (EnableReadPixel) pulses++;
         if (frame_done) dones++;
         check($sformatf("%s_px%0d", name, k), 32'(Pixel_data), conv(exp_q[k]));
      end
      @(negedge clk);
      check({name, "_done"}, 32'(frame_done), 1);
      check({name, "_px_zero_after"}, 32'(Pixel_data), 0);
      check({name, "_extra_pulses"}, pulses, 0);
      check({name, "_early_done"}, dones, 0);
      @(negedge clk);
      check({name, "_done_one_cycle"}, 32'(frame_done), 0);
      check({name, "_hold_busy"}, 32'(busy), 1);
   endtask

   task automatic rearm();
      @(negedge clk);
      next_frame = 1'b1;
      @(negedge clk);
      next_frame = 1'b0;
      check("rearm_ready", 32'(bus.in_ready), 1);
      check("rearm_busy", 32'(busy), 0);
   endtask

   initial begin
      int unsigned hold_acc;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      #3;
      check("rst_in_ready", 32'(bus.in_ready), 0);
      check("rst_enable", 32'(EnableReadPixel), 0);
      check("rst_pixel", 32'(Pixel_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(frame_done), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("post_rst_ready_low", 32'(bus.in_ready), 0);
      @(negedge clk);
      check("post_rst_ready_high", 32'(bus.in_ready), 1);

      send(NPIX, 0, 8'h00, 1'b0);
      stream_check("ramp");
`ifdef PIXEL_NORMALIZE_EN
      check("ramp_k0", 32'(got[0]), 32'h0);
      check("ramp_k1", 32'(got[1]), 32'd4);
      check("ramp_k128", 32'(got[128]), 32'd514);
      check("ramp_k255", 32'(got[255]), 32'd1024);
`else
      check("ramp_k0", 32'(got[0]), 32'h00000);
      check("ramp_k1", 32'(got[1]), 32'h00400);
      check("ramp_k128", 32'(got[128]), 32'h20000);
      check("ramp_k255", 32'(got[255]), 32'h3FC00);
`endif

      rearm();
      send(NPIX, 1, 8'hFF, 1'b1);
      stream_check("ff_burst");

      hold_acc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = 8'($urandom);
         if (bus.in_ready || Pixel_data != 0 || EnableReadPixel) hold_acc++;
      end
      check("hold_ignores_input", hold_acc, 0);
      bus.in_valid = 1'b0;
      rearm();
      send(NPIX, 1, 8'h80, 1'b0);
      stream_check("half");

      rearm();
      send(400, 2, 8'h00, 1'b1);
      rst_n = 1'b0;
      #2;
      check("midrst_ready", 32'(bus.in_ready), 0);
      check("midrst_busy", 32'(busy), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_ready_back", 32'(bus.in_ready), 1);
      send(NPIX, 1, 8'h10, 1'b0);
      stream_check("after_rst");

      rearm();
      send(NPIX, 2, 8'h00, 1'b1);
      stream_check("random");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end
endmodule
